// File: rtl/branch_pkg.sv
// Shared definitions for the branch prediction unit.
//   - RV32 conditional-branch funct3 codes
//   - 2-bit saturating counter encodings for the branch history table
//   - init state machine encodings
//   - saturating counter update helper
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,  // strongly not-taken
    WNT = 2'b01,  // weakly not-taken (initial value)
    WT  = 2'b10,  // weakly taken
    ST  = 2'b11   // strongly taken
  } bht_state_e;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } fsm_state_e;

  // Move a counter one step toward taken (up=1) or not-taken, clamping at
  // SNT and ST.
  function automatic logic [1:0] bht_next(input logic [1:0] cur, input logic up);
    logic [1:0] nxt;
    nxt = cur;
    if (up && cur != ST)        nxt = cur + 2'd1;
    else if (!up && cur != SNT) nxt = cur - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Bus between the branch prediction unit and the pipeline.
//   Prediction port (fetch):  pred_valid, pred_pc -> pred_out_valid, pred_taken
//   Status:                   ready
//   Resolve port (execute):   res_valid, branch, funct3, rs1_val, rs2_val,
//                             res_pc, res_pred_taken
//                             -> pc_src, mispredict, illegal
//   Statistics:               branch_cnt, mispred_cnt
// modport master: pipeline side.  modport slave: the prediction unit.
interface branch_predict_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             pred_valid;
  logic [XLEN-1:0]  pred_pc;
  logic             pred_out_valid;
  logic             pred_taken;
  logic             ready;

  logic             res_valid;
  logic             branch;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;
  logic [XLEN-1:0]  res_pc;
  logic             res_pred_taken;
  logic             pc_src;
  logic             mispredict;
  logic             illegal;

  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output pred_valid, pred_pc,
    output res_valid, branch, funct3, rs1_val, rs2_val, res_pc, res_pred_taken,
    input  pred_out_valid, pred_taken, ready,
    input  pc_src, mispredict, illegal,
    input  branch_cnt, mispred_cnt
  );

  modport slave (
    input  pred_valid, pred_pc,
    input  res_valid, branch, funct3, rs1_val, rs2_val, res_pc, res_pred_taken,
    output pred_out_valid, pred_taken, ready,
    output pc_src, mispredict, illegal,
    output branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_cmp.sv
// Combinational branch resolution.
//   en      in  resolve is valid and the instruction is a branch
//   funct3  in  branch type
//   rs1/rs2 in  operands, XLEN wide
//   pc_src  out branch actually taken (0 unless en and funct3 is legal)
//   illegal out en with funct3 010/011
module branch_cmp
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            en,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            pc_src,
  output logic            illegal
);

  logic eq, lt, ltu;
  logic taken, bad_f3;

  assign eq  = (rs1 == rs2);
  assign lt  = ($signed(rs1) < $signed(rs2));
  assign ltu = (rs1 < rs2);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    taken  = 1'b0;
    bad_f3 = 1'b0;
    unique case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = !lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = !ltu;
      default: bad_f3 = 1'b1;  // 010 / 011
    endcase
  end

  assign pc_src  = en & taken;
  assign illegal = en & bad_f3;

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction unit: resolves RV32 conditional branches, trains a
// direct-mapped table of 2-bit saturating counters, predicts for fetch and
// keeps saturating branch/mispredict statistics.
//   clk  rising-edge clock
//   rst  synchronous reset, active-high; restarts the table sweep
//   bus  branch_predict_unit_if.slave (prediction, resolve, statistics)
// After reset the table is swept to weakly not-taken, one entry per cycle;
// ready rises when the sweep is done. Predictions and table updates only
// happen once ready; the statistics count in every state.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic rst,
  branch_predict_unit_if.slave bus
);

  localparam int DEPTH = 2 ** IDX_BITS;

  fsm_state_e          state, state_next;
  logic [IDX_BITS-1:0] sweep, sweep_next;
  logic [1:0]          bht [DEPTH];

  logic [IDX_BITS-1:0] pred_idx, res_idx;
  logic                pc_src, illegal, legal, mispredict, in_run;
  logic                pred_out_valid_q, pred_taken_q;
  logic [CNT_W-1:0]    branch_cnt_q, mispred_cnt_q;

  // Word-aligned PCs: bits [1:0] and the bits above the index are not used.
  assign pred_idx = bus.pred_pc[IDX_BITS+1:2];
  assign res_idx  = bus.res_pc[IDX_BITS+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pred_pc[XLEN-1:IDX_BITS+2], bus.pred_pc[1:0],
                            bus.res_pc[XLEN-1:IDX_BITS+2],  bus.res_pc[1:0]};

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .en      (bus.res_valid & bus.branch),
    .funct3  (bus.funct3),
    .rs1     (bus.rs1_val),
    .rs2     (bus.rs2_val),
    .pc_src  (pc_src),
    .illegal (illegal)
  );

  assign legal      = bus.res_valid & bus.branch & ~illegal;
  assign mispredict = legal & (pc_src ^ bus.res_pred_taken);
  assign in_run     = (state == S_RUN);

  // ---- init state machine ----
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
      sweep <= '0;
    end else begin
      state <= state_next;
      sweep <= sweep_next;
    end
  end

  always_comb begin
    state_next = state;
    sweep_next = sweep;
    unique case (state)
      S_INIT: begin
        sweep_next = sweep + IDX_BITS'(1);
        if (sweep == '1) state_next = S_RUN;
      end
      S_RUN:   ;
      default: state_next = S_INIT;
    endcase
  end

  // ---- branch history table ----
  // NOTE: the table is deliberately not reset; the INIT sweep fills it, which
  // keeps it mappable to a RAM with a single write port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_INIT)
        bht[sweep] <= WNT;
      else if (legal)
        bht[res_idx] <= bht_next(bht[res_idx], pc_src);
    end
  end

  // ---- prediction register ----
  // Reads the table before any same-cycle update lands, so a read and an
  // update to the same index return the old counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_out_valid_q <= 1'b0;
      pred_taken_q     <= 1'b0;
    end else begin
      pred_out_valid_q <= bus.pred_valid & in_run;
      pred_taken_q     <= bus.pred_valid & in_run & bht[pred_idx][1];
    end
  end

  // ---- statistics (saturating, active in every state) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (legal) begin
      if (branch_cnt_q != '1)
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if (mispredict && mispred_cnt_q != '1)
        mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
    end
  end

  assign bus.pred_out_valid = pred_out_valid_q;
  assign bus.pred_taken     = pred_taken_q;
  assign bus.ready          = in_run;
  assign bus.pc_src         = pc_src;
  assign bus.mispredict     = mispredict;
  assign bus.illegal        = illegal;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;
  import branch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.XLEN(32), .CNT_W(16)) bus ();
  branch_predict_unit_if #(.XLEN(32), .CNT_W(2))  bus2 ();

  branch_predict_unit #(.XLEN(32), .IDX_BITS(6), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  branch_predict_unit #(.XLEN(32), .IDX_BITS(6), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input logic v, input logic br, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic pt);
    bus.res_valid      = v;
    bus.branch         = br;
    bus.funct3         = f3;
    bus.rs1_val        = a;
    bus.rs2_val        = b;
    bus.res_pc         = pc;
    bus.res_pred_taken = pt;
  endtask

  task automatic clear_res();
    set_res(1'b0, 1'b0, F3_BEQ, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  // One-cycle prediction request, then check the registered answer.
  task automatic predict_check(input string name, input logic [31:0] pc, input logic exp);
    bus.pred_valid = 1'b1;
    bus.pred_pc    = pc;
    tick();
    bus.pred_valid = 1'b0;
    check({name, " valid"}, {31'd0, bus.pred_out_valid}, 32'd1);
    check({name, " taken"}, {31'd0, bus.pred_taken}, {31'd0, exp});
  endtask

  // Counts cycles until ready, starting from an already-elapsed count.
  task automatic wait_ready(input int start, output int cycles);
    cycles = start;
    while (!bus.ready && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  typedef struct {
    logic        v;
    logic        br;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic        pt;
    logic        e_pc;
    logic        e_mp;
    logic        e_il;
  } vec_t;

  vec_t vecs [15];
  int   cyc;

  initial begin
    bus.pred_valid = 1'b0;
    bus.pred_pc    = '0;
    clear_res();
    bus2.pred_valid = 1'b0;
    bus2.pred_pc    = '0;
    bus2.res_valid  = 1'b0;
    bus2.branch     = 1'b0;
    bus2.funct3     = F3_BNE;
    bus2.rs1_val    = 32'd1;
    bus2.rs2_val    = 32'd2;
    bus2.res_pc     = '0;
    bus2.res_pred_taken = 1'b0;

    //          v     br    f3       rs1           rs2           pt    pc    mp    il
    vecs[0]  = '{1'b1, 1'b1, F3_BEQ,  32'd5,        32'd5,        1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, F3_BEQ,  32'd5,        32'd6,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, F3_BNE,  32'd5,        32'd6,        1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, F3_BNE,  32'd7,        32'd7,        1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, F3_BLT,  32'hFFFF_FFFF, 32'd1,       1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, F3_BLTU, 32'hFFFF_FFFF, 32'd1,       1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, F3_BGEU, 32'hFFFF_FFFF, 32'd1,       1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, F3_BGE,  32'hFFFF_FFFF, 32'd1,       1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, F3_BGE,  32'd1,        32'd1,        1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, F3_BLTU, 32'd1,        32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 3'b010,  32'd5,        32'd5,        1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 3'b011,  32'd5,        32'd6,        1'b1, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, F3_BEQ,  32'd5,        32'd5,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 3'b010,  32'd5,        32'd5,        1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, F3_BLT,  32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};

    // Combinational resolve table, applied while reset holds the state.
    #1;
    for (int i = 0; i < 15; i++) begin
      set_res(vecs[i].v, vecs[i].br, vecs[i].f3, vecs[i].a, vecs[i].b, 32'h40, vecs[i].pt);
      #1;
      check($sformatf("vec%0d pc_src", i),     {31'd0, bus.pc_src},     {31'd0, vecs[i].e_pc});
      check($sformatf("vec%0d mispredict", i), {31'd0, bus.mispredict}, {31'd0, vecs[i].e_mp});
      check($sformatf("vec%0d illegal", i),    {31'd0, bus.illegal},    {31'd0, vecs[i].e_il});
    end
    clear_res();

    tick();
    tick();
    check("reset ready",          {31'd0, bus.ready},          32'd0);
    check("reset pred_out_valid", {31'd0, bus.pred_out_valid}, 32'd0);
    check("reset pred_taken",     {31'd0, bus.pred_taken},     32'd0);
    check("reset branch_cnt",     {16'd0, bus.branch_cnt},     32'd0);
    check("reset mispred_cnt",    {16'd0, bus.mispred_cnt},    32'd0);

    // 1. Init sweep takes exactly 64 cycles; all entries weakly not-taken.
    rst = 1'b0;
    wait_ready(0, cyc);
    check("init cycles", cyc, 32'd64);
    for (int i = 0; i < 64; i++)
      predict_check($sformatf("init idx%0d", i), i * 4, 1'b0);
    tick();
    check("no request -> pred_out_valid", {31'd0, bus.pred_out_valid}, 32'd0);

    // 2. BEQ taken, predicted not-taken at PC 0x40.
    set_res(1'b1, 1'b1, F3_BEQ, 32'd5, 32'd5, 32'h40, 1'b0);
    #1;
    check("t2 pc_src",     {31'd0, bus.pc_src},     32'd1);
    check("t2 mispredict", {31'd0, bus.mispredict}, 32'd1);
    tick();
    clear_res();
    check("t2 mispred_cnt", {16'd0, bus.mispred_cnt}, 32'd1);
    check("t2 branch_cnt",  {16'd0, bus.branch_cnt},  32'd1);
    predict_check("t2 predict 0x40", 32'h40, 1'b1);
    predict_check("pc low bits ignored", 32'h43, 1'b1);

    // 4. Training walk at PC 0x100 (idx 0): 01->10->11->11, then down.
    for (int i = 0; i < 4; i++) begin
      set_res(1'b1, 1'b1, F3_BEQ, 32'd1, 32'd1, 32'h100, 1'b1);
      tick();
      clear_res();
      predict_check($sformatf("t4 taken%0d", i), 32'h100, 1'b1);
    end
    // Not-taken resolves with a same-index prediction in the same cycle:
    // the read sees the counter before the update.
    set_res(1'b1, 1'b1, F3_BEQ, 32'd1, 32'd2, 32'h100, 1'b0);
    bus.pred_valid = 1'b1;
    bus.pred_pc    = 32'h100;
    tick();
    check("t4 nt1 same-cycle read (11)", {31'd0, bus.pred_taken}, 32'd1);
    tick();
    check("t4 nt2 same-cycle read (10)", {31'd0, bus.pred_taken}, 32'd1);
    clear_res();
    bus.pred_valid = 1'b0;
    predict_check("t4 after nt2 (01)", 32'h100, 1'b0);
    check("t4 branch_cnt",  {16'd0, bus.branch_cnt},  32'd7);
    check("t4 mispred_cnt", {16'd0, bus.mispred_cnt}, 32'd1);

    // 5. Illegal funct3 leaves table and statistics alone.
    set_res(1'b1, 1'b1, 3'b010, 32'd9, 32'd9, 32'h40, 1'b0);
    #1;
    check("t5 illegal", {31'd0, bus.illegal}, 32'd1);
    check("t5 pc_src",  {31'd0, bus.pc_src},  32'd0);
    tick();
    clear_res();
    check("t5 branch_cnt",  {16'd0, bus.branch_cnt},  32'd7);
    check("t5 mispred_cnt", {16'd0, bus.mispred_cnt}, 32'd1);
    predict_check("t5 entry 0x40 unchanged", 32'h40, 1'b1);

    // 6. Reset mid-run: counters clear, sweep restarts, training is lost.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6 branch_cnt cleared",  {16'd0, bus.branch_cnt},  32'd0);
    check("t6 mispred_cnt cleared", {16'd0, bus.mispred_cnt}, 32'd0);
    check("t6 ready low",           {31'd0, bus.ready},       32'd0);
    // Request a prediction and resolve a legal branch during INIT.
    bus.pred_valid = 1'b1;
    bus.pred_pc    = 32'h40;
    set_res(1'b1, 1'b1, F3_BNE, 32'd1, 32'd2, 32'h40, 1'b0);
    tick();
    bus.pred_valid = 1'b0;
    clear_res();
    check("t6 no prediction in INIT", {31'd0, bus.pred_out_valid}, 32'd0);
    check("t6 branch_cnt counts in INIT",  {16'd0, bus.branch_cnt},  32'd1);
    check("t6 mispred_cnt counts in INIT", {16'd0, bus.mispred_cnt}, 32'd1);
    wait_ready(1, cyc);
    check("t6 init cycles", cyc, 32'd64);
    predict_check("t6 entry 0x40 re-inited",  32'h40,  1'b0);
    predict_check("t6 entry 0x100 re-inited", 32'h100, 1'b0);

    // Saturation with CNT_W=2: branch_cnt 1,2,3,3,3.
    check("sat start", {30'd0, bus2.branch_cnt}, 32'd0);
    bus2.res_valid = 1'b1;
    bus2.branch    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("sat branch_cnt %0d", i),  {30'd0, bus2.branch_cnt},  (i < 3) ? i + 1 : 3);
      check($sformatf("sat mispred_cnt %0d", i), {30'd0, bus2.mispred_cnt}, (i < 3) ? i + 1 : 3);
    end
    bus2.res_valid = 1'b0;
    tick();
    check("sat holds", {30'd0, bus2.branch_cnt}, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
